// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline interlock: stall/bubble/flush control from tracked ex/mem writers
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_vld,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_rs1_used,
    input  logic        ID_rs2_used,
    input  logic [4:0]  ID_rd,
    input  logic [1:0]  ID_mem_cmd,
    input  logic        EX_flush,
    output logic        HZ_stall,
    output logic        HZ_bubble,
    output logic        HZ_flush_ifid,
    output logic [15:0] HZ_stall_cnt
);

    typedef struct packed {
        logic       wen;
        logic [4:0] rd;
    } wr_entry_t;

    localparam logic [1:0] MEM_STORE = 2'b10;

    wr_entry_t ex_q;
    wr_entry_t mem_q;
    wr_entry_t ex_d;
    wr_entry_t id_entry;

    logic id_writer;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    // No forwarding network: any in-flight writer of a read source blocks ID.
    function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                     input wr_entry_t a, input wr_entry_t b);
        return used && (rs != 5'd0) &&
               ((a.wen && (a.rd == rs)) || (b.wen && (b.rd == rs)));
    endfunction

    always_comb begin
        id_writer   = ID_vld && (ID_rd != 5'd0) && (ID_mem_cmd != MEM_STORE);
        id_entry    = '0;
        if (id_writer) begin
            id_entry.wen = 1'b1;
            id_entry.rd  = ID_rd;
        end
        rs1_hit = src_hit(ID_rs1_used, ID_rs1, ex_q, mem_q);
        rs2_hit = src_hit(ID_rs2_used, ID_rs2, ex_q, mem_q);
        hazard  = ID_vld && (rs1_hit || rs2_hit);
    end

    always_comb begin
        HZ_stall      = 1'b0;
        HZ_bubble     = 1'b0;
        HZ_flush_ifid = 1'b0;
        if (!rst) begin
            if (EX_flush) begin
                HZ_bubble     = 1'b1;
                HZ_flush_ifid = 1'b1;
            end else begin
                HZ_stall  = hazard;
                HZ_bubble = hazard;
            end
        end
    end

    // A stalled or flushed slot enters EX as a bubble, so it never writes.
    always_comb begin
        ex_d = '0;
        if (ID_vld && !HZ_stall && !EX_flush) begin
            ex_d = id_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            HZ_stall_cnt <= 16'd0;
        end else if (HZ_stall && (HZ_stall_cnt != 16'hFFFF)) begin
            HZ_stall_cnt <= HZ_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against an issue-history model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_vld;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_rs1_used;
    logic        ID_rs2_used;
    logic [4:0]  ID_rd;
    logic [1:0]  ID_mem_cmd;
    logic        EX_flush;
    logic        HZ_stall;
    logic        HZ_bubble;
    logic        HZ_flush_ifid;
    logic [15:0] HZ_stall_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_vld(ID_vld), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_rd(ID_rd), .ID_mem_cmd(ID_mem_cmd), .EX_flush(EX_flush),
        .HZ_stall(HZ_stall), .HZ_bubble(HZ_bubble),
        .HZ_flush_ifid(HZ_flush_ifid), .HZ_stall_cnt(HZ_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Destination registers issued into EX during the last two cycles; 0 = nothing written.
    int unsigned issued [2];
    int unsigned m_cnt;

    logic        obs_stall, obs_bubble, obs_flush;
    logic [15:0] obs_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        int unsigned r1, r2;
        bit hz, e_stall, e_bubble, e_flush, writes;
        @(negedge clk);
        r1 = ID_rs1;
        r2 = ID_rs2;
        hz = ID_vld &&
             ((ID_rs1_used && r1 != 0 && (r1 == issued[0] || r1 == issued[1])) ||
              (ID_rs2_used && r2 != 0 && (r2 == issued[0] || r2 == issued[1])));
        e_flush  = !rst && EX_flush;
        e_stall  = !rst && !EX_flush && hz;
        e_bubble = !rst && (EX_flush || hz);
        obs_stall  = HZ_stall;
        obs_bubble = HZ_bubble;
        obs_flush  = HZ_flush_ifid;
        obs_cnt    = HZ_stall_cnt;
        check("stall",  {31'd0, obs_stall},  {31'd0, e_stall});
        check("bubble", {31'd0, obs_bubble}, {31'd0, e_bubble});
        check("flush",  {31'd0, obs_flush},  {31'd0, e_flush});
        check("cnt",    {16'd0, obs_cnt},    m_cnt);
        if (rst) begin
            issued[0] = 0;
            issued[1] = 0;
            m_cnt     = 0;
        end else begin
            writes    = ID_vld && ID_rd != 0 && ID_mem_cmd != 2'b10 && !e_stall && !EX_flush;
            issued[1] = issued[0];
            issued[0] = writes ? ID_rd : 0;
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2,
                          input logic [4:0] d, input logic [1:0] cmd);
        ID_vld = v; ID_rs1 = s1; ID_rs1_used = u1; ID_rs2 = s2; ID_rs2_used = u2;
        ID_rd = d; ID_mem_cmd = cmd; EX_flush = 1'b0;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        issued[0] = 0;
        issued[1] = 0;
        m_cnt     = 0;
        rst       = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("rst_cnt", {16'd0, obs_cnt}, 32'd0);
        check("rst_stall", {31'd0, obs_stall}, 32'd0);
        rst = 1'b0;

        // Back-to-back dependency
        set_id(1, 0, 0, 0, 0, 5, 2'b00); cycle();
        set_id(1, 5, 1, 0, 0, 0, 2'b00);
        cycle(); check("b2b_c1", {31'd0, obs_stall & obs_bubble}, 32'd1);
        cycle(); check("b2b_c2", {31'd0, obs_stall & obs_bubble}, 32'd1);
        cycle(); check("b2b_c3", {31'd0, obs_stall | obs_bubble}, 32'd0);
        check("b2b_cnt", {16'd0, obs_cnt}, 32'd2);

        // One-gap dependency, load writer
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 2'b01); cycle();
        set_id(1, 0, 0, 0, 0, 0, 2'b00); cycle();
        set_id(1, 0, 0, 7, 1, 0, 2'b00);
        cycle(); check("gap_c1", {31'd0, obs_stall}, 32'd1);
        cycle(); check("gap_c2", {31'd0, obs_stall}, 32'd0);
        check("gap_cnt", {16'd0, obs_cnt}, 32'd1);

        // No-hazard cases
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 2'b10); cycle();
        set_id(1, 7, 1, 0, 0, 0, 2'b00); cycle(); check("store_nohz", {31'd0, obs_stall}, 32'd0);
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 2'b00); cycle();
        set_id(1, 0, 1, 0, 1, 0, 2'b00); cycle(); check("x0_nohz", {31'd0, obs_stall}, 32'd0);
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 2'b00); cycle();
        set_id(1, 9, 0, 9, 0, 0, 2'b00); cycle(); check("unused_nohz", {31'd0, obs_stall}, 32'd0);
        do_reset();
        set_id(1, 0, 0, 0, 0, 6, 2'b11); cycle();
        set_id(1, 6, 1, 0, 0, 0, 2'b00); cycle(); check("rsvd_writer", {31'd0, obs_stall}, 32'd1);

        // Flush during stall; flushed writer rd=4 must not enter EX
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 2'b00); cycle();
        set_id(1, 3, 1, 0, 0, 4, 2'b00); cycle(); check("fl_pre", {31'd0, obs_stall}, 32'd1);
        EX_flush = 1'b1; cycle();
        check("fl_stall",  {31'd0, obs_stall},  32'd0);
        check("fl_bubble", {31'd0, obs_bubble}, 32'd1);
        check("fl_ifid",   {31'd0, obs_flush},  32'd1);
        set_id(1, 4, 1, 0, 0, 0, 2'b00); cycle(); check("fl_next", {31'd0, obs_stall}, 32'd0);

        // Reset mid-stall with a non-zero count
        set_id(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        set_id(1, 0, 0, 0, 0, 5, 2'b00); cycle();
        set_id(1, 5, 1, 0, 0, 0, 2'b00); rst = 1'b1; cycle();
        check("rm_stall",  {31'd0, obs_stall},  32'd0);
        check("rm_bubble", {31'd0, obs_bubble}, 32'd0);
        rst = 1'b0; cycle();
        check("rm_after", {31'd0, obs_stall}, 32'd0);
        check("rm_cnt", {16'd0, obs_cnt}, 32'd0);

        // Randomized traffic over a small register set to force collisions
        for (int i = 0; i < 800; i++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 2'($urandom));
            EX_flush = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        // Counter saturation: self-dependent writer stalls two of every three cycles
        do_reset();
        set_id(1, 5, 1, 0, 0, 5, 2'b00);
        guard = 0;
        while (m_cnt < 65535 && guard < 99000) begin
            cycle();
            guard++;
        end
        check("sat_reach", {31'd0, guard < 99000}, 32'd1);
        for (int i = 0; i < 12; i++) cycle();
        check("sat_hold", {16'd0, obs_cnt}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-003 SHALL have ports ID_vld, input, 1: the ID stage holds a valid instruction.
REQ-004 SHALL have ports ID_rs1 and ID_rs2, input, 5 each: source register indices of the ID instruction.
REQ-005 SHALL have ports ID_rs1_used and ID_rs2_used, input, 1 each: the ID instruction actually reads that source.
REQ-006 SHALL have port ID_rd, input, 5: destination register index of the ID instruction.
REQ-007 SHALL have port ID_mem_cmd, input, 2, encoded as: 00 none, 01 load, 10 store, 11 reserved (treated as 00).
REQ-008 SHALL have port EX_flush, input, 1: a branch/jump resolved taken in EX this cycle.
REQ-009 SHALL have port HZ_stall, output, 1: hold PC and the IF/ID register.
REQ-010 SHALL have port HZ_bubble, output, 1: load an invalid slot into ID/EX.
REQ-011 SHALL have port HZ_flush_ifid, output, 1: invalidate IF/ID.
REQ-012 SHALL have port HZ_stall_cnt, output, 16: saturating count of stall cycles.

Function
REQ-013 SHALL track two in-flight writer entries, ex and mem, each holding {wen, rd[4:0]}; there is no forwarding network, and the RF write-before-read bypass covers WB, so WB is not tracked.
REQ-014 SHALL treat an ID instruction as a writer when all hold: ID_vld=1, ID_rd!=0, and ID_mem_cmd!=10.
REQ-015 SHALL compute hazard combinationally as ID_vld AND (source1 hit OR source2 hit).
- sourceN hit: ID_rsN_used=1, ID_rsN!=0, and ID_rsN equals the rd of any entry with wen=1.
REQ-016 SHALL, when EX_flush=1, drive HZ_flush_ifid=1, HZ_bubble=1 and HZ_stall=0, regardless of hazard.
REQ-017 SHALL otherwise drive HZ_stall=hazard, HZ_bubble=hazard and HZ_flush_ifid=0.
REQ-018 SHALL advance the entries every cycle with no enable:
- mem <= ex.
- ex <= ID writer entry if ID_vld=1, HZ_stall=0 and EX_flush=0.
- ex <= {0,0} in every other case.
REQ-019 SHALL therefore stall at most 2 consecutive cycles per dependency: 2 cycles when the match is in ex, 1 cycle when the match is in mem.
REQ-020 SHALL stall once when both sources hit; the stall lasts until no entry matches either source.
REQ-021 SHALL ignore register x0 on both the source side and the destination side.
REQ-022 SHALL increment HZ_stall_cnt by 1 on each cycle with HZ_stall=1 and hold it at 16'hFFFF once reached (no wrap).
REQ-023 SHALL have purely combinational HZ_stall, HZ_bubble and HZ_flush_ifid, with zero-cycle latency from the inputs and the registered entries.
REQ-024 SHALL keep ID_mem_cmd=01 (load) on the same 2-cycle interlock path as ALU writers; there is no special load-use case.

Reset
REQ-025 SHALL clear both entries to {wen=0, rd=0} and HZ_stall_cnt to 0 on any clock edge with rst=1.
REQ-026 SHALL, while rst=1, drive HZ_stall=0, HZ_bubble=0 and HZ_flush_ifid=0 regardless of other inputs.
REQ-027 SHALL, when rst asserts mid-stall, drop the stall on the same cycle and report no hazard on the first cycle after rst deasserts.

Verification
REQ-028 Back-to-back dependency:
- Stimulus: cycle0 ID: rd=5, cmd=00. Cycle1 ID: rs1=5, rs1_used=1.
- Response: HZ_stall=HZ_bubble=1 in cycles 1 and 2, 0 in cycle 3; HZ_stall_cnt=2.
REQ-029 One-gap dependency:
- Stimulus: writer rd=7, then an independent instruction, then a reader rs2=7.
- Response: exactly one stall cycle.
REQ-030 No-hazard cases:
- A store with ID_rd=7 followed by a reader rs1=7: no stall.
- A writer rd=0 followed by a reader rs1=0: no stall.
- A match with rs1_used=0: no stall.
REQ-031 Flush during stall:
- Stimulus: a stall is active and EX_flush=1.
- Response: HZ_stall=0, HZ_bubble=1, HZ_flush_ifid=1; the next ex entry has wen=0.
REQ-032 Counter saturation:
- Stimulus: preload the count via 65535 stall cycles, then force more stalls.
- Response: HZ_stall_cnt stays at 16'hFFFF.
REQ-033 Reset mid-stall:
- Stimulus: rst=1 on the 1st stall cycle.
- Response: outputs 0 in that cycle; HZ_stall_cnt=0; no stall after release with an unchanged reader in ID.
